instr_queue: RTL

Decoupling FIFO between decode and issue. Decode pushes one packed `queue_item_t` per cycle and issue pops one per cycle with the same valid/ready handshake on both sides. The queue absorbs issue stalls without back-pressuring fetch until it is full. A single-cycle `flush` from branch resolution discards every entry.

---
 rtl/ctrl_sigs.sv | 30 +++
 rtl/iq_ram.sv | 28 ++
 rtl/instr_queue.sv | 93 +++++++++
 3 files changed

// File: rtl/ctrl_sigs.sv
// Shared control-path types: the packed decoded instruction carried from
// decode to issue, its micro-op encoding, and the default queue depth.
package ctrl_sigs;

  typedef enum logic [6:0] {
    UOP_NOP  = 7'd0,
    UOP_ADDI = 7'd1,
    UOP_ADD  = 7'd2,
    UOP_LW   = 7'd3,
    UOP_SW   = 7'd4,
    UOP_BEQ  = 7'd5,
    UOP_JAL  = 7'd6
  } uop_e;

  // 50-bit decoded instruction; taken/shadowed are branch-prediction state
  // owned by later stages and passed through untouched here.
  typedef struct packed {
    uop_e        uopcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
    logic [5:0]  br_tag;
    logic        taken;
    logic        shadowed;
  } queue_item_t;

  localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/iq_ram.sv
// Entry storage for instr_queue: DEPTH x queue_item_t register array with one
// synchronous write port and one asynchronous read port.
module iq_ram
  import ctrl_sigs::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  queue_item_t          wdata,
  input  logic [AW-1:0]        raddr,
  output queue_item_t          rdata
);

  queue_item_t mem [DEPTH];

  // NOTE: storage is deliberately not reset; stale entries are never visible
  // because the occupancy count masks them, and an unreset array maps to
  // plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Decode-to-issue decoupling FIFO with valid/ready on both sides and flush.
// Optional same-cycle bypass of an empty queue: define IQ_BYPASS_EN.
module instr_queue
  import ctrl_sigs::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  queue_item_t                enq_item,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output queue_item_t                deq_item,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count_q;
  logic          empty, full;
  logic          enq_fire, deq_fire, bypass_take;
  logic          mem_write, mem_pop;
  queue_item_t   rd_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Registered state only, so issue stalls never reach decode combinationally.
  assign enq_ready = !rst && !full;

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    deq_valid   = 1'b0;
    deq_item    = '0;
    bypass_take = 1'b0;
    if (!empty && !flush) begin
      deq_valid = 1'b1;
      deq_item  = rd_data;
    end
`ifdef IQ_BYPASS_EN
    else if (empty && enq_valid && !flush && !rst) begin
      deq_valid   = 1'b1;
      deq_item    = enq_item;
      bypass_take = deq_ready;
    end
`endif
  end

  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign deq_fire  = deq_valid && deq_ready;
  // A bypassed item is consumed in flight: no write, no pointer movement.
  assign mem_write = enq_fire && !bypass_take;
  assign mem_pop   = deq_fire && !bypass_take;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (mem_write) tail <= tail + PW'(1);
      if (mem_pop)   head <= head + PW'(1);
      count_q <= count_q + CW'(mem_write) - CW'(mem_pop);
    end
  end

  iq_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_write),
    .waddr (tail),
    .wdata (enq_item),
    .raddr (head),
    .rdata (rd_data)
  );

  assign count = count_q;

endmodule
